// File: rtl/instr_pkg.sv
// Shared types for the RV32I instruction encoder: format codes, opcodes,
// the decoded input record and the output-buffer occupancy states.
package instr_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'b000,
        FMT_I = 3'b001,
        FMT_S = 3'b010,
        FMT_B = 3'b011,
        FMT_J = 3'b100,
        FMT_U = 3'b101
    } fmt_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // fmt is kept as raw bits so the illegal codes 110/111 stay representable
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } instr_rec_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // True when v is the sign extension of its low n bits.
    function automatic logic sext_fits(input logic [31:0] v, input int n);
        logic signed [31:0] t;
        t = $signed(v << (32 - n)) >>> (32 - n);
        return (t == $signed(v));
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer. With INSTR_ENCODER_RANGE_CHECK_EN defined,
// immediates that do not fit their format also raise err (word still packed).
module instr_pack
    import instr_pkg::*;
(
    input  instr_rec_t  rec,
    output logic [31:0] word,
    output logic        err
);

    logic illegal;
    logic range_err;

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (rec.fmt)
            FMT_R: word = {rec.funct7, rec.rs2, rec.rs1, rec.funct3, rec.rd, rec.op};
            FMT_I: word = {rec.imm[11:0], rec.rs1, rec.funct3, rec.rd, rec.op};
            FMT_S: word = {rec.imm[11:5], rec.rs2, rec.rs1, rec.funct3, rec.imm[4:0], rec.op};
            FMT_B: word = {rec.imm[12], rec.imm[10:5], rec.rs2, rec.rs1, rec.funct3,
                           rec.imm[4:1], rec.imm[11], rec.op};
            FMT_J: word = {rec.imm[20], rec.imm[10:1], rec.imm[11], rec.imm[19:12],
                           rec.rd, rec.op};
            FMT_U: word = {rec.imm[31:12], rec.rd, rec.op};
            default: illegal = 1'b1;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    always_comb begin
        range_err = 1'b0;
        case (rec.fmt)
            FMT_I, FMT_S: range_err = !sext_fits(rec.imm, 12);
            FMT_B:        range_err = !sext_fits(rec.imm, 13) || rec.imm[0];
            FMT_J:        range_err = !sext_fits(rec.imm, 21) || rec.imm[0];
            FMT_U:        range_err = |rec.imm[11:0];
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign err = illegal | range_err;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a 1- or 2-entry elastic output buffer.
// Optional immediate range checking is enabled by INSTR_ENCODER_RANGE_CHECK_EN.
//
// state     | meaning
// ----------|------------------------------------------
// OCC_EMPTY | no word buffered, out_valid low
// OCC_ONE   | head entry valid, input still accepted
// OCC_TWO   | head and tail valid, in_ready low
module instr_encoder
    import instr_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_fmt,
    input  logic [6:0]      in_op,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_word,
    output logic            out_err,
    output logic            busy
);

    instr_rec_t  rec;
    logic [31:0] pack_word;
    logic        pack_err;

    assign rec = '{fmt: in_fmt, op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                   funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    instr_pack u_pack (
        .rec  (rec),
        .word (pack_word),
        .err  (pack_err)
    );

    if (DEPTH == 1) begin : g_depth1
        logic        valid_q, valid_d;
        logic [31:0] word_q, word_d;
        logic        err_q, err_d;
        logic        ready;
        logic        push;

        // ready passes out_ready straight through so a full register can reload
        assign ready = !valid_q || out_ready;
        assign push  = in_valid && ready;

        always_comb begin
            valid_d = valid_q;
            word_d  = word_q;
            err_d   = err_q;
            if (push) begin
                valid_d = 1'b1;
                word_d  = pack_word;
                err_d   = pack_err;
            end else if (out_ready) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                word_q  <= 32'h0;
                err_q   <= 1'b0;
            end else begin
                valid_q <= valid_d;
                word_q  <= word_d;
                err_q   <= err_d;
            end
        end

        assign in_ready  = ready;
        assign out_valid = valid_q;
        assign out_word  = word_q;
        assign out_err   = err_q;
        assign busy      = valid_q;
    end else begin : g_depth2
        occ_e        state_q, state_d;
        logic [31:0] head_word_q, head_word_d;
        logic [31:0] tail_word_q, tail_word_d;
        logic        head_err_q, head_err_d;
        logic        tail_err_q, tail_err_d;
        logic        in_ready_q, in_ready_d;
        logic        out_valid_q, out_valid_d;
        logic        push;
        logic        pop;

        assign push = in_valid && in_ready_q;
        assign pop  = out_valid_q && out_ready;

        always_comb begin
            state_d     = state_q;
            head_word_d = head_word_q;
            head_err_d  = head_err_q;
            tail_word_d = tail_word_q;
            tail_err_d  = tail_err_q;
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_word_d = pack_word;
                        head_err_d  = pack_err;
                        state_d     = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_word_d = pack_word;
                        head_err_d  = pack_err;
                    end else if (push) begin
                        tail_word_d = pack_word;
                        tail_err_d  = pack_err;
                        state_d     = OCC_TWO;
                    end else if (pop) begin
                        state_d     = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        head_word_d = tail_word_q;
                        head_err_d  = tail_err_q;
                        state_d     = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
            in_ready_d  = (state_d != OCC_TWO);
            out_valid_d = (state_d != OCC_EMPTY);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q     <= OCC_EMPTY;
                head_word_q <= 32'h0;
                head_err_q  <= 1'b0;
                tail_word_q <= 32'h0;
                tail_err_q  <= 1'b0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                head_word_q <= head_word_d;
                head_err_q  <= head_err_d;
                tail_word_q <= tail_word_d;
                tail_err_q  <= tail_err_d;
                in_ready_q  <= in_ready_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign in_ready  = in_ready_q;
        assign out_valid = out_valid_q;
        assign out_word  = head_word_q;
        assign out_err   = head_err_q;
        assign busy      = out_valid_q;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed RV32I vectors, buffer/backpressure
// and mid-stream reset cases, then randomized records against a reference model.
module tb_instr_encoder;
    import instr_pkg::*;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic        out_err;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];
    bit          rnd_ready = 1'b0;
    bit          hold_valid = 1'b0;
    logic [32:0] hold_val;

    always #5 clk = ~clk;

    instr_encoder #(.XLEN(32), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_err   (out_err),
        .busy      (busy)
    );

    // Reference encoder: fields placed by arithmetic shifts of the immediate.
    function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        logic        e;
        int          si;
        si = int'(imm);
        e  = 1'b0;
        case (f)
            3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                      | (32'(rd) << 7) | 32'(op);
            3'd1: begin
                w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                    | (32'(rd) << 7) | 32'(op);
                e = RC && (si < -2048 || si > 2047);
            end
            3'd2: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                    | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
                e = RC && (si < -2048 || si > 2047);
            end
            3'd3: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                    | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                    | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'(op);
                e = RC && (si < -4096 || si > 4095 || (imm & 1) != 0);
            end
            3'd4: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (32'(rd) << 7) | 32'(op);
                e = RC && (si < -(1 << 20) || si > (1 << 20) - 1 || (imm & 1) != 0);
            end
            3'd5: begin
                w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
                e = RC && ((imm & 32'hFFF) != 0);
            end
            default: begin
                w = 32'h0;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard for every output handshake.
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid && out_valid)
                chk("hold_stable", {out_err, out_word}, hold_val);
            hold_valid = out_valid && !out_ready;
            hold_val   = {out_err, out_word};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {1'b1, out_word}, {1'b0, out_word});
                end else begin
                    chk("out_word", {out_err, out_word}, exp_q.pop_front());
                end
            end
        end
    end

    // Drives one record starting at a falling edge; returns at the falling edge after transfer.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input bit use_exp, input logic [32:0] exp);
        bit acc;
        acc = 1'b0;
        in_fmt = f; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(use_exp ? exp : ref_enc(f, op, rd, rs1, rs2, f3, f7, imm));
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 33'd0, 33'd1);
    endtask

    task automatic set_ready(input bit rnd, input logic v);
        #1;
        rnd_ready = rnd;
        out_ready = v;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 33'(exp_q.size()), 33'd0);
    endtask

    initial begin
        logic [31:0] imm;
        logic [31:0] bnd[13];
        bnd = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4095, -32'sd4096, 32'd4094,
                32'h000FFFFE, 32'hFFF00000, 32'h00100000, 32'h1000, 32'hFFFFF000, 32'd3};

        #12;
        chk("rst_out_valid", 33'(out_valid), 33'd0);
        chk("rst_out_word", {out_err, out_word}, 33'd0);
        chk("rst_busy", 33'(busy), 33'd0);
        chk("rst_in_ready", 33'(in_ready), 33'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // addi x5,x6,-1 with latency check one cycle after transfer
        send(3'd1, OP_I, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1, {1'b0, 32'hFFF30293});
        chk("addi_latency", {out_valid, out_word}, {1'b1, 32'hFFF30293});
        send(3'd2, OP_SW, 5'd0, 5'd2, 5'd7, 3'd2, 7'd0, 32'd8, 1, {1'b0, 32'h00712423});
        send(3'd3, OP_BEQ, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1, {1'b0, 32'hFE208EE3});
        send(3'd4, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, {1'b0, 32'h001000EF});
        send(3'd7, OP_R, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, 32'd0, 1, {1'b1, 32'h0});
        send(3'd1, OP_I, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h800, 1, {RC, 32'h80010093});
        send(3'd3, OP_BEQ, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1, {RC, 32'h00000163});
        wait_drain();

        // Backpressure: two accepted, third blocked until a pop
        set_ready(0, 1'b0);
        send(3'd0, OP_R, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 0, 33'd0);
        send(3'd5, OP_LUI, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 0, 33'd0);
        in_fmt = 3'd1; in_op = OP_LW; in_rd = 5'd4; in_rs1 = 5'd8; in_rs2 = 5'd0;
        in_funct3 = 3'd2; in_funct7 = 7'd0; in_imm = 32'd16;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("full_in_ready", {busy, in_ready}, 33'b10);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("ready_after_pop", 33'(in_ready), 33'd1);
        @(posedge clk);
        exp_q.push_back(ref_enc(3'd1, OP_LW, 5'd4, 5'd8, 5'd0, 3'd2, 7'd0, 32'd16));
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();

        // Reset with two entries buffered: nothing replayed afterwards
        set_ready(0, 1'b0);
        send(3'd1, OP_I, 5'd7, 5'd7, 5'd0, 3'd0, 7'd0, 32'd5, 0, 33'd0);
        send(3'd1, OP_I, 5'd8, 5'd8, 5'd0, 3'd0, 7'd0, 32'd6, 0, 33'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out", {out_err, out_word}, 33'd0);
        chk("midrst_valid_busy", {out_valid, busy}, 33'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        send(3'd1, OP_I, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1, {1'b0, 32'hFFF30293});
        wait_drain();
        repeat (4) @(negedge clk);

        // Randomized records with random downstream stalls
        set_ready(1, 1'b1);
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
                2: imm = bnd[$urandom_range(0, 12)];
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), imm, 0, 33'd0);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        set_ready(0, 1'b1);
        wait_drain();
        @(negedge clk);
        #1;
        chk("final_busy", 33'(busy), 33'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decode path: packs a decoded instruction record (format, opcode, register indices, funct fields, 32-bit immediate) into a 32-bit RV32I machine word.
- Used by the program-loader / self-test path to write instruction memory.
- Valid/ready streaming on both sides; output is registered through a small elastic buffer so the memory writer can stall.

Parameters:
- XLEN, 32, data/immediate width; only 32 is supported.
- DEPTH, 2, output buffer entries; legal values are 1 and 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input record valid.
- in_ready  out  1  encoder can accept a record this cycle.
- in_fmt  in  3  format code (package enum): R=000, I=001, S=010, B=011, J=100, U=101; 110 and 111 are illegal.
- in_op  in  7  opcode field.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field.
- in_imm  in  32  byte-offset immediate, sign-extended.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_word  out  32  encoded instruction.
- out_err  out  1  word flagged illegal or out of range; qualified by out_valid.
- busy  out  1  buffer non-empty.

Behaviour:
- Reset, asynchronous: buffer empty; out_valid=0, out_word=0, out_err=0, busy=0.
- in_ready after reset:
  - DEPTH=2: in_ready=1.
  - DEPTH=1: in_ready follows the DEPTH=1 rule below.
- Transfer rule: a transfer occurs when valid && ready on the same edge. Input fields are sampled only at an input transfer.
- Latency: the encoded word appears on out_* the cycle after the input transfer when the buffer was empty. Throughput is 1 word/cycle.
- Field packing:
  - Common to all formats: op→[6:0]. rd→[11:7] for R, I, J, U. funct3→[14:12] for R, I, S, B. rs1→[19:15] for R, I, S, B. rs2→[24:20] for R, S, B. funct7→[31:25] for R.
  - I: imm[11:0]→[31:20].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→[31], imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→[7].
  - J: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12].
  - U: imm[31:12]→[31:12].
- Illegal fmt (110/111): out_word=0, out_err=1. This is independent of the macro.
- DEPTH=2 buffer:
  - Occupancy FSM with states EMPTY, ONE, TWO.
  - in_ready = (state != TWO), driven from a register; no combinational path from out_ready.
  - EMPTY: in→ONE.
  - ONE: in&&!out→TWO; out&&!in→EMPTY; in&&out→ONE.
  - TWO: out→ONE.
  - Simultaneous push and pop in ONE: the new entry replaces the head on the next cycle.
  - Order is FIFO.
- DEPTH=1 buffer:
  - in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
  - Simultaneous pop and push reloads the register.
- out_word and out_err hold stable while out_valid && !out_ready.
- Reset asserted mid-stream discards all entries immediately; nothing is replayed after release.
- busy = (state != EMPTY).

Optional Feature:
- Macro: INSTR_ENCODER_RANGE_CHECK_EN.
- Defined: out_err=1 when any of the following holds:
  - I or S: imm is not sign-representable in 12 bits.
  - B: imm not representable in 13 bits, or imm[0]≠0.
  - J: imm not representable in 21 bits, or imm[0]≠0.
  - U: imm[11:0]≠0.
  - In all these cases the word is still packed with truncated fields.
- Undefined: the range logic is absent. out_err is driven only by an illegal fmt; silent truncation.

Decomposition:
- Package instr_pkg holds:
  - fmt_e enum (R, I, S, B, J, U).
  - Opcode constants: OP_R=0110011, OP_I=0010011, OP_LW=0000011, OP_SW=0100011, OP_BEQ=1100011, OP_JAL=1101111, OP_LUI=0110111.
  - A packed struct instr_rec_t for the input record.
  - Occupancy state enum.
- One natural sub-module: instr_pack, a combinational packer that takes instr_rec_t and produces word and err. It also holds the range-check logic under the macro.
- The buffer and FSM live in the top module.

Test Plan:
- I-type addi x5,x6,-1 (fmt=I, op=0010011, rd=5, rs1=6, f3=0, imm=FFFFFFFF), out_ready=1 → out_word=FFF30293, out_err=0, one cycle after transfer.
- S sw x7,8(x2): fmt=S, op=0100011, rs1=2, rs2=7, f3=010, imm=8 → 00712423.
- B beq x1,x2,-4 → FE208EE3. J jal x1,2048 → 001000EF.
- Back-to-back 3 records with out_ready=0 → in_ready drops after 2 accepted (DEPTH=2). Then out_ready=1 → words drain in order, and in_ready rises the cycle after the first pop.
- Assert reset with TWO entries buffered → out_valid=0, busy=0 immediately. After release, the first new record is output correctly.
- With INSTR_ENCODER_RANGE_CHECK_EN: fmt=I, imm=0x800 → out_err=1, word[31:20]=800. B with imm=3 → out_err=1. fmt=111 → word 0, err=1 both with and without the macro.
